// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues busywait-handshaked word reads and queues {pc, instr} pairs for IF/ID.
// Optional macro IF_BUBBLE_NOP_EN: present addi x0,x0,0 instead of zero on IF_INSTRUCTION while no entry is valid.
`timescale 1ns/1ps

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_READ,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_INSTRUCTION,
    output logic        IF_VALID
);

`ifdef IF_BUBBLE_NOP_EN
    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0013;
`else
    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
`endif

    localparam int unsigned    PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned    CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        ST_FETCH,
        ST_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     drain_addr_q, drain_addr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     fifo_pc_q    [DEPTH];
    logic [31:0]     fifo_instr_q [DEPTH];

    logic            complete;
    logic            req_stuck;
    logic            push;
    logic            pop;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect that lands on a still-busy request must let that request finish before refetching.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH: if (BRANCH_TAKEN && req_stuck) state_d = ST_DRAIN;
            ST_DRAIN: if (!IMEM_BUSYWAIT)            state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        IMEM_READ = 1'b0;
        IMEM_ADDR = pc_q;
        unique case (state_q)
            ST_FETCH: begin
                IMEM_READ = (count_q < FULL);
                IMEM_ADDR = pc_q;
            end
            ST_DRAIN: begin
                IMEM_READ = 1'b1;
                IMEM_ADDR = drain_addr_q;
            end
            default: begin
                IMEM_READ = 1'b0;
                IMEM_ADDR = pc_q;
            end
        endcase
    end

    assign complete  = IMEM_READ && !IMEM_BUSYWAIT;
    assign req_stuck = IMEM_READ && IMEM_BUSYWAIT;
    assign push      = !BRANCH_TAKEN && (state_q == ST_FETCH) && complete;
    assign pop       = !BRANCH_TAKEN && IF_VALID && !STALL;

    always_comb begin
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        if (BRANCH_TAKEN) begin
            pc_d     = BRANCH_TARGET & 32'hFFFF_FFFC;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if ((state_q == ST_FETCH) && req_stuck) begin
                drain_addr_d = pc_q;
            end
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else if (push) begin
            fifo_pc_q[wr_ptr_q]    <= pc_q;
            fifo_instr_q[wr_ptr_q] <= IMEM_READDATA;
        end
    end

    assign IF_VALID       = (count_q != '0);
    assign IF_PC          = IF_VALID ? fifo_pc_q[rd_ptr_q]    : '0;
    assign IF_INSTRUCTION = IF_VALID ? fifo_instr_q[rd_ptr_q] : BUBBLE_INSTR;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based reference model checked every cycle, directed scenarios plus random traffic.
`timescale 1ns/1ps

module tb_if_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_BUBBLE_NOP_EN
    localparam logic [31:0] BUBBLE   = 32'h0000_0013;
`else
    localparam logic [31:0] BUBBLE   = 32'h0000_0000;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        STALL = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = '0;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_READ;
    logic [31:0] IMEM_READDATA = '0;
    logic        IMEM_BUSYWAIT = 1'b0;
    logic [31:0] IF_PC;
    logic [31:0] IF_INSTRUCTION;
    logic        IF_VALID;

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .STALL(STALL),
        .BRANCH_TAKEN(BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET),
        .IMEM_ADDR(IMEM_ADDR),
        .IMEM_READ(IMEM_READ),
        .IMEM_READDATA(IMEM_READDATA),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .IF_PC(IF_PC),
        .IF_INSTRUCTION(IF_INSTRUCTION),
        .IF_VALID(IF_VALID)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    int          errors = 0;
    int          checks = 0;
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_daddr;
    bit          m_drain;
    bit          prev_hold;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit exp_read();
        return m_drain || (m_q.size() < DEPTH);
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_drain ? m_daddr : m_pc;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc      = RESET_PC;
        m_daddr   = '0;
        m_drain   = 1'b0;
        prev_hold = 1'b0;
        prev_addr = '0;
    endtask

    task automatic compare_all();
        bit v;
        v = (m_q.size() != 0);
        check32("imem_read", {31'b0, IMEM_READ}, {31'b0, exp_read()});
        check32("imem_addr", IMEM_ADDR, exp_addr());
        check32("if_valid", {31'b0, IF_VALID}, {31'b0, v});
        check32("if_pc", IF_PC, v ? m_q[0].pc : 32'h0);
        check32("if_instr", IF_INSTRUCTION, v ? m_q[0].ins : BUBBLE);
        if (prev_hold) begin
            check32("hold_read", {31'b0, IMEM_READ}, 32'd1);
            check32("hold_addr", IMEM_ADDR, prev_addr);
        end
    endtask

    // Drives one cycle of inputs at a falling edge, advances the model over the next rising edge, then compares.
    task automatic tick(input bit s, input bit b, input logic [31:0] t, input bit w);
        bit rd;
        rd            = exp_read();
        STALL         = s;
        BRANCH_TAKEN  = b;
        BRANCH_TARGET = t;
        IMEM_BUSYWAIT = w;
        IMEM_READDATA = mem_word(IMEM_ADDR);
        prev_hold     = rd && w;
        prev_addr     = exp_addr();
        if (b) begin
            if (m_drain) begin
                if (!w) m_drain = 1'b0;
            end else if (rd && w) begin
                m_drain = 1'b1;
                m_daddr = m_pc;
            end
            m_q.delete();
            m_pc = {t[31:2], 2'b00};
        end else if (m_drain) begin
            if (!w) m_drain = 1'b0;
        end else begin
            if (m_q.size() > 0 && !s) void'(m_q.pop_front());
            if (rd && !w) begin
                m_q.push_back('{pc: m_pc, ins: mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge CLK);
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge CLK);
        check32("rst_valid", {31'b0, IF_VALID}, 32'd0);
        check32("rst_pc", IF_PC, 32'h0);
        check32("rst_instr", IF_INSTRUCTION, BUBBLE);
        check32("rst_addr", IMEM_ADDR, RESET_PC);
        check32("rst_read", {31'b0, IMEM_READ}, 32'd1);
        RESET = 1'b1;

        tick(0, 0, 0, 0);
        check32("first_pc", IF_PC, 32'h0);
        check32("first_instr", IF_INSTRUCTION, 32'hA5A5_0000);
        check32("first_addr", IMEM_ADDR, 32'h4);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        check32("seq_pc8", IF_PC, 32'h8);

        for (int i = 0; i < 5; i++) tick(1, 0, 0, 0);
        check32("stall_read", {31'b0, IMEM_READ}, 32'd0);
        check32("stall_head", IF_PC, 32'h8);
        check32("stall_addr", IMEM_ADDR, 32'h10);
        tick(0, 0, 0, 0);
        check32("rel_pcC", IF_PC, 32'hC);
        tick(0, 0, 0, 0);
        check32("rel_pc10", IF_PC, 32'h10);

        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
        check32("pre_br_addr", IMEM_ADDR, 32'h20);
        tick(0, 1, 32'h103, 1);
        check32("drain_valid", {31'b0, IF_VALID}, 32'd0);
        check32("drain_addr", IMEM_ADDR, 32'h20);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        check32("drain_addr_hold", IMEM_ADDR, 32'h20);
        tick(0, 0, 0, 0);
        check32("post_drain_addr", IMEM_ADDR, 32'h100);
        check32("post_drain_valid", {31'b0, IF_VALID}, 32'd0);
        tick(0, 0, 0, 0);
        check32("target_pc", IF_PC, 32'h100);
        check32("target_instr", IF_INSTRUCTION, 32'hA5A5_0100);

        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        check32("full_read", {31'b0, IMEM_READ}, 32'd0);
        tick(1, 1, 32'hFFFF_FFF8, 0);
        check32("flush_valid", {31'b0, IF_VALID}, 32'd0);
        check32("flush_addr", IMEM_ADDR, 32'hFFFF_FFF8);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        check32("wrap_addr", IMEM_ADDR, 32'h0);
        check32("wrap_head", IF_PC, 32'hFFFF_FFFC);

        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0,
                 $urandom, $urandom_range(0, 9) < 4);
        end

        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        #2;
        RESET = 1'b0;
        #1;
        check32("mid_rst_valid", {31'b0, IF_VALID}, 32'd0);
        check32("mid_rst_pc", IF_PC, 32'h0);
        check32("mid_rst_instr", IF_INSTRUCTION, BUBBLE);
        check32("mid_rst_addr", IMEM_ADDR, RESET_PC);
        model_reset();
        @(negedge CLK);
        RESET = 1'b1;
        compare_all();
        tick(0, 0, 0, 0);
        check32("after_rst_pc", IF_PC, RESET_PC);
        check32("after_rst_addr", IMEM_ADDR, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch unit for the RV32IM pipeline; owns the program counter and drives the IF-side inputs (PC, instruction) of the IF/ID pipeline register. It issues word reads to instruction memory through a busywait handshake and buffers returned words in a small FIFO, so fetching can continue while the pipeline is stalled. It handles taken-branch/jump redirects from later stages, including redirects that arrive while a memory read is still pending.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- DEPTH, 2, fetch FIFO entries (power of two, ≥2)
- CLK  input  1  clock, rising-edge
- RESET  input  1  asynchronous, active-low reset
- STALL  input  1  IF/ID hold request from hazard unit; head not consumed
- BRANCH_TAKEN  input  1  redirect request, single-cycle pulse
- BRANCH_TARGET  input  32  redirect address; bits [1:0] ignored (forced 0)
- IMEM_ADDR  output  32  instruction memory word address
- IMEM_READ  output  1  read request
- IMEM_READDATA  input  32  read data, valid in completion cycle
- IMEM_BUSYWAIT  input  1  memory not ready; request must be held
- IF_PC  output  32  PC of FIFO head, to IF/ID register
- IF_INSTRUCTION  output  32  instruction of FIFO head, to IF/ID register
- IF_VALID  output  1  FIFO head valid

## Operation
- Registers: PC (next fetch address), FIFO of {pc, instr} × DEPTH, count, state.
- States: FETCH, DRAIN.
- FETCH: IMEM_READ = 1 when count < DEPTH or a request is already in progress; IMEM_ADDR = PC.
- Once IMEM_READ is asserted, IMEM_ADDR and IMEM_READ hold stable until completion. Completion is a rising edge with IMEM_READ=1 and IMEM_BUSYWAIT=0.
- Completion (no redirect): push {PC, IMEM_READDATA}; PC ← PC+4 (wraps modulo 2^32).
- Pop: at a rising edge with IF_VALID=1 and STALL=0. Push and pop at the same edge leaves count unchanged.
- One request outstanding at most, so a completing push always has space.
- Redirect (BRANCH_TAKEN=1 at edge):
  - Flush the FIFO (count ← 0) and set PC ← {BRANCH_TARGET[31:2], 2'b00}.
  - If a request is pending and not completing at this edge (BUSYWAIT=1), go to DRAIN. The old request's address is held in a separate register until it completes.
  - If a request completes at the same edge, discard its data and stay in FETCH.
- DRAIN: IMEM_READ=1 with the old address until completion; discard the data; then go to FETCH and fetch from the new PC.
  - A further BRANCH_TAKEN in DRAIN overwrites PC only.
- Priorities: redirect > push/pop. STALL never blocks a redirect flush.
- IF_VALID = (count ≠ 0) and state-independent. IF_PC/IF_INSTRUCTION show the head entry when valid.

## Timing
- Reset (RESET=0, async): PC=RESET_PC, count=0, state=FETCH, IF_VALID=0, IF_PC=0, IF_INSTRUCTION=0 (or NOP, see Configuration).
- First cycle after release: IMEM_READ=1, IMEM_ADDR=RESET_PC.
- IMEM_ADDR and IMEM_READ are combinational from registers only (no input-to-output path).
- Zero-wait memory: fetch-to-IF_VALID latency is 1 cycle; sustained throughput is 1 instruction/cycle with STALL=0.
- N busywait cycles add N cycles of latency.
- Redirect to the first target instruction at IF_VALID: 2 cycles with zero-wait memory and no pending request. In DRAIN, add the remaining busywait cycles plus 1.
- Reset asserted mid-request drops the request immediately; memory is expected to be reset together with this block.

## Configuration
- IF_BUBBLE_NOP_EN defined: when IF_VALID=0, IF_INSTRUCTION = 32'h0000_0013 (addi x0,x0,0) and IF_PC = 0. Reset value of IF_INSTRUCTION is also 32'h0000_0013.
- Undefined: when IF_VALID=0, IF_INSTRUCTION = 32'h0000_0000 and IF_PC = 0. Downstream gates on IF_VALID.

## Test plan
- Reset release, zero-wait memory returning addr-tagged words, STALL=0 -> IMEM_ADDR 0,4,8,… on consecutive cycles; IF_PC/IF_INSTRUCTION pairs appear one cycle later, IF_VALID=1 continuously.
- STALL=1 for 5 cycles, DEPTH=2 -> FIFO fills and IMEM_READ drops to 0; head holds PC 0x8. After release, PCs 0x8, 0xC, 0x10 follow with no gap or duplicate.
- BRANCH_TAKEN with target 0x103 while IMEM_BUSYWAIT=1 for 3 more cycles at addr 0x20 -> IMEM_ADDR stays 0x20 until completion and that word is discarded. Next IMEM_ADDR is 0x100; IF_VALID=0 until the 0x100 word returns.
- BRANCH_TAKEN and STALL both high with FIFO full -> FIFO empty, IF_VALID=0 next cycle; fetch restarts at the target.
- PC=0xFFFF_FFFC sequential fetch -> next IMEM_ADDR 0x0000_0000.
- RESET pulsed low mid-busywait -> outputs go to reset values immediately; after release, IMEM_ADDR=RESET_PC and IF_INSTRUCTION is 0x13 or 0x0 per IF_BUBBLE_NOP_EN.
